// File: rtl/pkt_rr_arb_pkg.sv
// Shared definitions for the packet round-robin arbiter: FSM encoding,
// the end-of-packet rule and a log2 helper for index widths.
package pkt_rr_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_t;

    // Minimum bit width able to index `value` entries (at least 1).
    function automatic int clog2_f(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) w++;
        return w;
    endfunction

    // A non-zero ctrl word only closes a packet once body words have been seen;
    // before that it is a module header.
    function automatic logic is_eop(input logic ctrl_nonzero, input logic in_body);
        return ctrl_nonzero & in_body;
    endfunction

endpackage

// File: rtl/pkt_rr_arb_rr_pick.sv
// Combinational rotate-and-priority-encode: first set request at or after ptr,
// wrapping modulo N.
module rr_pick
    import pkt_rr_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int QW = clog2_f(N)
) (
    input  logic [N-1:0]  req,
    input  logic [QW-1:0] ptr,
    output logic [QW-1:0] winner,
    output logic          valid
);

    logic [QW:0] slot;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        slot   = '0;
        // Walk offsets from furthest to nearest so the nearest hit is written last.
        for (int i = N - 1; i >= 0; i--) begin
            slot = {1'b0, ptr} + (QW+1)'(i);
            if (slot >= (QW+1)'(N)) slot = slot - (QW+1)'(N);
            if (req[slot[QW-1:0]]) begin
                winner = slot[QW-1:0];
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pkt_rr_arb.sv
// Packet-level round-robin arbiter merging NUM_QUEUES packet streams into one.
// Optional macro PKT_RR_ARB_PRIO0_EN gives queue 0 absolute priority in IDLE.
module pkt_rr_arb
    import pkt_rr_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int NUM_QUEUES = 4,
    localparam int QW = clog2_f(NUM_QUEUES)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_QUEUES-1:0]            in_req,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
    input  logic [NUM_QUEUES-1:0]            in_wr,
    output logic [NUM_QUEUES-1:0]            in_rdy,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [CTRL_WIDTH-1:0]            out_ctrl,
    output logic                             out_wr,
    input  logic                             out_rdy,
    output logic [QW-1:0]                    grant_idx,
    output logic                             busy
);

    arb_state_t           state;
    logic [QW-1:0]        rr_ptr;
    logic                 in_body;

    logic [NUM_QUEUES-1:0] pick_req;
    logic [QW-1:0]        rr_idx;
    logic                 rr_valid;
    logic [QW-1:0]        win_idx;
    logic                 win_valid;
    logic                 ptr_adv;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [CTRL_WIDTH-1:0] sel_ctrl;
    logic                 sel_wr;
    logic                 accept;
    logic                 eop;
    logic [QW-1:0]        next_ptr;

`ifdef PKT_RR_ARB_PRIO0_EN
    // Queue 0 bypasses the rotation; the others rotate among themselves.
    assign pick_req  = {in_req[NUM_QUEUES-1:1], 1'b0};
    assign win_idx   = in_req[0] ? '0 : rr_idx;
    assign win_valid = in_req[0] | rr_valid;
    assign ptr_adv   = (grant_idx != '0);
`else
    assign pick_req  = in_req;
    assign win_idx   = rr_idx;
    assign win_valid = rr_valid;
    assign ptr_adv   = 1'b1;
`endif

    rr_pick #(.N(NUM_QUEUES)) u_rr_pick (
        .req    (pick_req),
        .ptr    (rr_ptr),
        .winner (rr_idx),
        .valid  (rr_valid)
    );

    // Granted-queue mux; in_rdy only ever opens for the holder of the grant.
    always_comb begin
        sel_data = '0;
        sel_ctrl = '0;
        sel_wr   = 1'b0;
        in_rdy   = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (grant_idx == QW'(i)) begin
                sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_ctrl  = in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH];
                sel_wr    = in_wr[i];
                in_rdy[i] = (state == XFER) && out_rdy;
            end
        end
    end

    assign accept   = (state == XFER) && sel_wr && out_rdy;
    assign eop      = accept && is_eop(|sel_ctrl, in_body);
    assign next_ptr = (grant_idx == QW'(NUM_QUEUES - 1)) ? '0 : grant_idx + QW'(1);

    // NOTE: state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            busy      <= 1'b0;
            in_body   <= 1'b0;
            out_wr    <= 1'b0;
            out_data  <= '0;
            out_ctrl  <= '0;
        end else begin
            out_wr <= accept;
            if (accept) begin
                out_data <= sel_data;
                out_ctrl <= sel_ctrl;
            end

            case (state)
                IDLE: begin
                    if (win_valid) begin
                        grant_idx <= win_idx;
                        busy      <= 1'b1;
                        in_body   <= 1'b0;
                        state     <= XFER;
                    end
                end
                XFER: begin
                    if (eop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (ptr_adv) rr_ptr <= next_ptr;
                    end else if (accept && (sel_ctrl == '0)) begin
                        in_body <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_rr_arb.sv
// Self-checking bench for pkt_rr_arb: a spec-level model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pkt_rr_arb;

    localparam int DW = 64;
    localparam int CW = 8;
    localparam int NQ = 4;
    localparam logic [63:0] ROGUE_WORD = 64'h03AA_BBCC_DDEE_FF00;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NQ-1:0]    in_req;
    logic [NQ*DW-1:0] in_data;
    logic [NQ*CW-1:0] in_ctrl;
    logic [NQ-1:0]    in_wr;
    logic [NQ-1:0]    in_rdy;
    logic [DW-1:0]    out_data;
    logic [CW-1:0]    out_ctrl;
    logic             out_wr;
    logic             out_rdy = 1'b1;
    logic [1:0]       grant_idx;
    logic             busy;

    pkt_rr_arb #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .NUM_QUEUES(NQ)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_req    (in_req),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .in_wr     (in_wr),
        .in_rdy    (in_rdy),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .out_wr    (out_wr),
        .out_rdy   (out_rdy),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- upstream sources ----------------
    logic [63:0] s_data [NQ][32];
    logic [7:0]  s_ctrl [NQ][32];
    int          s_len  [NQ];
    int          s_pos  [NQ];
    logic        rogue = 1'b0;
    logic [NQ-1:0] src_take;
    int          tag = 1;

    always_comb begin
        in_req  = '0;
        in_wr   = '0;
        in_data = '0;
        in_ctrl = '0;
        for (int i = 0; i < NQ; i++) begin
            if (s_pos[i] < s_len[i]) begin
                in_req[i]              = 1'b1;
                in_data[i*DW +: DW]    = s_data[i][s_pos[i]];
                in_ctrl[i*CW +: CW]    = s_ctrl[i][s_pos[i]];
                in_wr[i]               = in_rdy[i];
            end
        end
        if (rogue) begin
            in_wr[3]            = 1'b1;
            in_data[3*DW +: DW] = ROGUE_WORD;
            in_ctrl[3*CW +: CW] = '0;
        end
    end

    initial forever begin
        @(posedge clk);
        src_take = in_wr & in_rdy;
        #1;
        for (int i = 0; i < NQ; i++)
            if (src_take[i] && s_pos[i] < s_len[i]) s_pos[i] = s_pos[i] + 1;
    end

    task automatic clear_sources();
        for (int i = 0; i < NQ; i++) begin
            s_len[i] = 0;
            s_pos[i] = 0;
        end
    endtask

    // Packet of n words: header FF, body 00..., EOP 0F.
    task automatic load_pkt(input int q, input int n);
        for (int j = 0; j < n; j++) begin
            s_ctrl[q][s_len[q]] = (j == 0) ? 8'hFF : ((j == n - 1) ? 8'h0F : 8'h00);
            s_data[q][s_len[q]] = {8'(q), 40'h0, 16'(tag)};
            tag      = tag + 1;
            s_len[q] = s_len[q] + 1;
        end
    endtask

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Spec-level model: who holds the grant, where the rotation starts, and
    // what the registered output must show after each edge.
    bit          m_busy = 0;
    int          m_grant = 0;
    int          m_ptr = 0;
    bit          m_body = 0;
    bit          m_acc;
    bit          m_found;
    logic        exp_wr = 1'b0;
    logic [63:0] exp_data = '0;
    logic [7:0]  exp_ctrl = '0;

    initial forever begin
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_busy = 0; m_grant = 0; m_ptr = 0; m_body = 0;
            exp_wr = 1'b0; exp_data = '0; exp_ctrl = '0;
        end else begin
            m_acc  = m_busy && in_wr[m_grant] && out_rdy;
            exp_wr = m_acc;
            if (m_acc) begin
                exp_data = in_data[m_grant*DW +: DW];
                exp_ctrl = in_ctrl[m_grant*CW +: CW];
            end
            if (!m_busy) begin
                m_found = 0;
                for (int k = 0; k < NQ; k++) begin
                    if (!m_found && in_req[(m_ptr + k) % NQ]) begin
                        m_grant = (m_ptr + k) % NQ;
                        m_found = 1;
                    end
                end
                if (m_found) begin
                    m_busy = 1;
                    m_body = 0;
                end
            end else if (m_acc) begin
                if (exp_ctrl != 0 && m_body) begin
                    m_busy = 0;
                    m_ptr  = (m_grant + 1) % NQ;
                end else if (exp_ctrl == 0) begin
                    m_body = 1;
                end
            end
        end
    end

    // Per-cycle compare plus output monitor, both half a cycle after the edge.
    logic [63:0] obs[$];
    int          grant_log[$];
    int          wr_count = 0;
    int          cyc = 0;
    int          first_cyc = -1;
    int          last_cyc = -1;
    logic        prev_busy = 1'b0;
    logic [NQ-1:0] exp_rdy;

    initial forever begin
        @(negedge clk);
        cyc++;
        if (reset) begin
            exp_rdy = '0;
            if (m_busy) exp_rdy[m_grant] = out_rdy;
            check("cyc_out_wr",   64'(out_wr),    64'(exp_wr));
            check("cyc_out_data", out_data,       exp_data);
            check("cyc_out_ctrl", 64'(out_ctrl),  64'(exp_ctrl));
            check("cyc_busy",     64'(busy),      64'(m_busy));
            check("cyc_grant",    64'(grant_idx), 64'(m_grant));
            check("cyc_in_rdy",   64'(in_rdy),    64'(exp_rdy));
            if (out_wr) begin
                obs.push_back(out_data);
                wr_count++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (busy && !prev_busy) grant_log.push_back(int'(grant_idx));
            prev_busy = busy;
        end else begin
            prev_busy = 1'b0;
        end
    end

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(busy), 64'd0);
        @(negedge clk);
        #1;
    endtask

    task automatic wait_busy(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (!busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(busy), 64'd1);
    endtask

    task automatic wait_grants(input string name, input int target);
        int k;
        k = 0;
        while (grant_log.size() < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(grant_log.size() >= target), 64'd1);
    endtask

    task automatic start_capture();
        obs.delete();
        wr_count  = 0;
        first_cyc = -1;
        last_cyc  = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: run exceeded time limit, want completion");
        $fatal(1);
    end

    // ---------------- directed scenarios ----------------
    int base;
    int b0;
    int q3_seen;
    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        clear_sources();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",     64'(busy),      64'd0);
        check("rst_out_wr",   64'(out_wr),    64'd0);
        check("rst_grant",    64'(grant_idx), 64'd0);
        check("rst_out_data", out_data,       64'd0);
        check("rst_in_rdy",   64'(in_rdy),    64'd0);
        @(posedge clk); #2 reset = 1'b1;

        // Single 5-word packet on queue 2.
        @(posedge clk); #2;
        start_capture();
        load_pkt(2, 5);
        @(posedge clk); #3;
        check("t1_grant", 64'(grant_idx), 64'd2);
        check("t1_busy",  64'(busy),      64'd1);
        wait_idle("t1_idle");
        check("t1_wr_pulses", 64'(wr_count), 64'd5);
        check("t1_last_ctrl", 64'(out_ctrl), 64'h0F);
        if (obs.size() >= 5) check("t1_last_data", obs[4], {8'd2, 40'h0, 16'd5});

        // rr_ptr must now be 3: with queues 0 and 3 pending, 3 wins first.
        base = grant_log.size();
        load_pkt(0, 3);
        load_pkt(3, 3);
        wait_grants("ptr_grants", base + 2);
        wait_idle("ptr_idle");
        if (grant_log.size() >= base + 2) begin
            check("ptr_first",  64'(grant_log[base]),     64'd3);
            check("ptr_second", 64'(grant_log[base + 1]), 64'd0);
        end

        // Fresh start, all queues requesting 3-word packets.
        reset = 1'b0;
        clear_sources();
        @(negedge clk); #2 reset = 1'b1;
        start_capture();
        base = grant_log.size();
        load_pkt(0, 3);
        load_pkt(0, 3);
        load_pkt(1, 3);
        load_pkt(2, 3);
        load_pkt(3, 3);
        wait_grants("t2_grants", base + 5);
        wait_idle("t2_idle");
        if (grant_log.size() >= base + 5)
            for (int i = 0; i < 5; i++)
                check($sformatf("t2_order%0d", i), 64'(grant_log[base + i]), 64'(exp_order[i]));
        check("t2_wr_pulses", 64'(wr_count), 64'd15);
        check("t2_span",      64'(last_cyc - first_cyc + 1), 64'd19);

        // Stall queue 1 mid-body for four cycles.
        start_capture();
        b0 = s_len[1];
        load_pkt(1, 7);
        wait_busy("t3_busy");
        check("t3_grant", 64'(grant_idx), 64'd1);
        repeat (3) @(posedge clk);
        #2 out_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #3;
            check("t3_stall_rdy",   64'(in_rdy[1]), 64'd0);
            check("t3_stall_wr",    64'(out_wr),    64'd0);
            check("t3_stall_grant", 64'(grant_idx), 64'd1);
        end
        out_rdy = 1'b1;
        wait_idle("t3_idle");
        check("t3_wr_pulses", 64'(wr_count), 64'd7);
        if (obs.size() >= 7)
            for (int i = 0; i < 7; i++)
                check($sformatf("t3_word%0d", i), obs[i], s_data[1][b0 + i]);

        // Queue 3 strobes in_wr without a grant while queue 0 transfers.
        start_capture();
        b0 = s_len[0];
        load_pkt(0, 5);
        wait_busy("t4_busy");
        check("t4_grant", 64'(grant_idx), 64'd0);
        @(posedge clk); #2 rogue = 1'b1;
        repeat (3) @(posedge clk);
        #2 rogue = 1'b0;
        wait_idle("t4_idle");
        check("t4_wr_pulses", 64'(wr_count), 64'd5);
        q3_seen = 0;
        foreach (obs[i]) if (obs[i][63:56] == 8'd3) q3_seen++;
        check("t4_no_q3", 64'(q3_seen), 64'd0);
        if (obs.size() >= 5)
            for (int i = 0; i < 5; i++)
                check($sformatf("t4_word%0d", i), obs[i], s_data[0][b0 + i]);

        // Async reset mid-body of queue 2.
        load_pkt(2, 6);
        wait_busy("t5_busy");
        check("t5_grant", 64'(grant_idx), 64'd2);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
        clear_sources();
        #1;
        check("t5_rst_out_wr", 64'(out_wr),    64'd0);
        check("t5_rst_busy",   64'(busy),      64'd0);
        check("t5_rst_grant",  64'(grant_idx), 64'd0);
        @(negedge clk); #2 reset = 1'b1;
        load_pkt(3, 3);
        @(posedge clk); #3;
        check("t5_regrant", 64'(grant_idx), 64'd3);
        check("t5_rebusy",  64'(busy),      64'd1);
        wait_idle("t5_idle");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pkt_rr_arb.md
Name: pkt_rr_arb

Overview:
- Packet-level round-robin arbiter. It merges NUM_QUEUES upstream packet streams into one in_data/in_ctrl/in_wr stream for the header-removal stage and downstream output queues.
- Grants one requester at a time and holds the grant until the end-of-packet word.
- Packets are never interleaved.
- Framing: words with ctrl != 0 before any ctrl == 0 word are module headers. Ctrl == 0 words are body. The first ctrl != 0 word after a body word is end-of-packet (EOP).

Parameters:
- DATA_WIDTH, 64, data word width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl width.
- NUM_QUEUES, 4, number of requesters (2..8).
- QW, log2(NUM_QUEUES), grant index width (localparam).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_req  in  NUM_QUEUES  bit i=1: queue i has a packet pending.
- in_data  in  NUM_QUEUES*DATA_WIDTH  flattened; queue i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_ctrl  in  NUM_QUEUES*CTRL_WIDTH  flattened likewise.
- in_wr  in  NUM_QUEUES  per-queue word strobe.
- in_rdy  out  NUM_QUEUES  per-queue accept.
- out_data  out  DATA_WIDTH  registered word.
- out_ctrl  out  CTRL_WIDTH  registered ctrl.
- out_wr  out  1  registered strobe.
- out_rdy  in  1  downstream can take a word next cycle (almost-full style, slack >= 2).
- grant_idx  out  QW  current/last granted queue.
- busy  out  1  grant held.

Behaviour:
- Reset (reset=0, async):
  - State IDLE; rr_ptr=0; grant_idx=0; busy=0.
  - out_wr=0; out_data=0; out_ctrl=0; in_body=0.
- FSM states: IDLE, XFER.
- IDLE:
  - If in_req is all zeros, stay in IDLE.
  - Otherwise select the first set bit scanning from rr_ptr upward, wrapping modulo NUM_QUEUES.
  - Register the winner into grant_idx, set busy=1, clear in_body, go to XFER.
  - in_rdy is all zeros in IDLE.
- XFER:
  - in_rdy[grant_idx] = out_rdy (combinational). All other in_rdy bits are 0.
  - A word is accepted when in_wr[g] && in_rdy[g].
  - Accepted word: in_body <= 1 if ctrl == 0.
  - Accepted word with ctrl != 0 and in_body=1 is EOP. On EOP:
    - go to IDLE; busy <= 0;
    - rr_ptr <= (grant_idx+1) mod NUM_QUEUES.
- Output pipeline, 1-cycle latency:
  - out_wr <= accept.
  - out_data/out_ctrl <= selected queue's word when accept; otherwise they hold their value.
- Gaps and stalls:
  - Minimum gap between packets is 1 cycle, the IDLE arbitration cycle. Back-to-back throughput is packet_len/(packet_len+1).
  - in_wr on a non-granted queue, or while in_rdy=0, is a protocol violation. The word is ignored and state is unchanged.
  - out_rdy deassertion mid-packet stalls the transfer; the grant is held indefinitely.
- in_req deassertion during XFER has no effect; the grant is released only at EOP.
- Header-only words (ctrl != 0 while in_body=0) pass through and do not end the packet.
- Reset mid-packet aborts the transfer immediately. Downstream sees a truncated packet; recovery is upstream/system responsibility.

Optional Feature:
- Macro: PKT_RR_ARB_PRIO0_EN.
- Defined: in IDLE, queue 0 wins whenever in_req[0]=1, regardless of rr_ptr. The other queues use round-robin among themselves. rr_ptr advances only after a non-zero queue's EOP.
- Undefined: pure round-robin as above.

Decomposition:
- Shared package/include (pkt_arb_defines.vh):
  - state encodings (IDLE=1'b0, XFER=1'b1);
  - the EOP-detect rule as a function/macro;
  - the log2 function.
- One sub-module, rr_pick:
  - combinational rotate-and-priority-encode;
  - inputs: req vector, ptr;
  - outputs: winner index and valid.
- The FSM and datapath mux stay in pkt_rr_arb.

Test Plan:
- Single packet, queue 2: words ctrl FF, 00, 00, 00, 0F.
  - Requires grant_idx=2 one cycle after in_req=4'b0100.
  - Requires 5 out_wr pulses, each 1 cycle after the matching in_wr, data equal.
  - Requires busy=0 and rr_ptr=3 after EOP.
- All queues request continuously, 3-word packets each.
  - Grant order 0,1,2,3,0.
  - Exactly one idle out_wr=0 cycle between packets.
- Stall: drop out_rdy for 4 cycles mid-body of queue 1.
  - in_rdy[1]=0 those cycles; no out_wr.
  - Grant is held; transfer resumes with no lost or duplicated words.
- Interleave attempt: queue 3 pulses in_wr while queue 0 is granted.
  - Queue 3's words never appear on the output; queue 0's packet is intact.
- Async reset asserted mid-body.
  - out_wr=0 and busy=0 the same cycle.
  - After release with in_req=4'b1000: grant_idx=3.
- With PKT_RR_ARB_PRIO0_EN: rr_ptr=2, in_req=4'b1101 → grant 0. After queue 0's EOP with in_req=4'b1100 → grant 2.
